mc_proc_controller: RTL and testbench
=====================================

MC_PROC_CONTROLLER -- requirements
Module: mc_proc_controller

Interface
REQ-001 Parameter OP_BIT_WIDTH, default 4: width of op1/op2/opAlu/opCond.
REQ-002 Parameter OP2_SUB, default 4'b0110: ALU op forced for compare/branch classes.
REQ-003 Parameter MEM_TIMEOUT, default 16: max cycles a memory request may wait for memReady.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  synchronous, active-high.
REQ-006 lock  in  1  run enable; low freezes FSM/counters and forces every write-enable/request output low.
REQ-007 op1, op2  in  OP_BIT_WIDTH each  primary/secondary opcode fields from instruction register.
REQ-008 outCond  in  1  condition unit result, valid in EXEC.
REQ-009 memReady  in  1  memory completes current request this cycle.
REQ-010 memReq, memWe  out  1 each  memory request strobe; write qualifier.
REQ-011 irWrtEn, pcWrtEn, useImmPc  out  1 each  latch IR; update PC; PC source = branch/JAL target.
REQ-012 wrtEnReg  out  1; wrtRegSel  out  2 (0 ALU, 1 mem, 2 PC)  register-file write control.
REQ-013 useZeroExe, useImmExe, isMvhi  out  1 each; opAlu, opCond  out  OP_BIT_WIDTH  execute controls.
REQ-014 state  out  3  current FSM state; busErr  out  1; illegalOp, instrRetired  out  1 each (pulses).

Function
REQ-015 Classes by op1: ALU 0000, ALUI 1000, LW 1001, SW 0101, CMP 0010, CMPI 1010, BR 0110, JAL 1011; any other value is ILLEGAL.
REQ-016 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, ERR=5; codes 6/7 unreachable and return to FETCH next cycle.
REQ-017 FETCH: memReq=1, memWe=0; on memReady: irWrtEn=1, pcWrtEn=1 (PC+4), useImmPc=0, go DECODE; else hold.
REQ-018 DECODE: one cycle, no strobes, go EXEC; ILLEGAL instead pulses illegalOp, goes FETCH, no writes.
REQ-019 EXEC: one cycle; opAlu=OP2_SUB for CMP/CMPI/BR else op2; opCond=op2; useImmExe=op1[3] or SW; isMvhi = op1[3]&~op1[1]&op2[0]&op2[1]; useZeroExe = (BR&op2[2]) | isMvhi.
REQ-020 EXEC exit: BR -> FETCH with pcWrtEn=useImmPc=outCond; JAL -> WB with pcWrtEn=useImmPc=1; LW/SW -> MEM; ALU/ALUI/CMP/CMPI -> WB.
REQ-021 Execute controls of REQ-019 are held valid in EXEC, MEM and WB (decoded from op1/op2, which are stable until next irWrtEn).
REQ-022 MEM: memReq=1, memWe=SW; on memReady SW -> FETCH, LW -> WB; else hold.
REQ-023 WB: wrtEnReg=1, wrtRegSel = 2 for JAL, 1 for LW, 0 otherwise; go FETCH.
REQ-024 instrRetired pulses 1 cycle on every transition into FETCH from EXEC, MEM or WB; not on ILLEGAL or ERR.
REQ-025 Wait counter (width clog2(MEM_TIMEOUT)+1): clears on entry to FETCH/MEM and on memReady, increments each cycle memReq=1 & memReady=0.
REQ-026 Counter reaching MEM_TIMEOUT-1 with memReady=0 -> ERR next cycle; memReady in same cycle wins (normal transition).
REQ-027 ERR: all strobes 0, busErr=1, absorbing until reset.
REQ-028 lock=0: state and counter hold, all of memReq/memWe/irWrtEn/pcWrtEn/wrtEnReg/illegalOp/instrRetired =0; memReady ignored; resumes identically when lock=1.
REQ-029 Strobes are combinational from state, op1/op2, outCond, memReady, lock; state/counter/busErr are registered.

Reset
REQ-030 reset=1 at clk edge: state=FETCH, counter=0, busErr=0; overrides lock and any in-flight request (mid-MEM/ERR included).
REQ-031 In the reset cycle and while reset held, all write/request/pulse outputs are 0; first FETCH request appears the cycle after reset deasserts.

Verification
REQ-032 ALU op1=0000, memReady=1 in FETCH -> states 0,1,2,4,0; wrtEnReg=1 in WB with wrtRegSel=0; instrRetired once; 4 cycles.
REQ-033 LW op1=1001, memReady delayed 3 cycles in MEM -> MEM held 4 cycles, memWe=0, then WB wrtRegSel=1.
REQ-034 BR op1=0110, op2=0100, outCond=1 -> EXEC: opAlu=0110, useZeroExe=1, pcWrtEn=useImmPc=1, next FETCH; outCond=0 -> pcWrtEn=0.
REQ-035 SW op1=0101 with memReady never asserted, MEM_TIMEOUT=16 -> ERR after 16 MEM cycles, busErr=1, memReq=0; memReady on cycle 16 instead -> FETCH.
REQ-036 lock dropped 5 cycles during MEM of SW -> no memReq/memWe, state held at 3; reset asserted mid-MEM -> state=0, busErr=0 next cycle.

Source files
------------

// File: rtl/mc_proc_controller.sv
// Multi-cycle processor control FSM: fetch/decode/execute/memory/writeback
// sequencing with memory wait timeout, run lock and bus-error trap.
module mc_proc_controller #(
    parameter int                      OP_BIT_WIDTH = 4,
    parameter logic [OP_BIT_WIDTH-1:0] OP2_SUB      = 4'b0110,
    parameter int                      MEM_TIMEOUT  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    lock,
    input  logic [OP_BIT_WIDTH-1:0] op1,
    input  logic [OP_BIT_WIDTH-1:0] op2,
    input  logic                    outCond,
    input  logic                    memReady,
    output logic                    memReq,
    output logic                    memWe,
    output logic                    irWrtEn,
    output logic                    pcWrtEn,
    output logic                    useImmPc,
    output logic                    wrtEnReg,
    output logic [1:0]              wrtRegSel,
    output logic                    useZeroExe,
    output logic                    useImmExe,
    output logic                    isMvhi,
    output logic [OP_BIT_WIDTH-1:0] opAlu,
    output logic [OP_BIT_WIDTH-1:0] opCond,
    output logic [2:0]              state,
    output logic                    busErr,
    output logic                    illegalOp,
    output logic                    instrRetired
);

    localparam int CW = $clog2(MEM_TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LIM = CW'(MEM_TIMEOUT - 1);

    localparam logic [OP_BIT_WIDTH-1:0] OP_ALU  = OP_BIT_WIDTH'(4'b0000);
    localparam logic [OP_BIT_WIDTH-1:0] OP_ALUI = OP_BIT_WIDTH'(4'b1000);
    localparam logic [OP_BIT_WIDTH-1:0] OP_LW   = OP_BIT_WIDTH'(4'b1001);
    localparam logic [OP_BIT_WIDTH-1:0] OP_SW   = OP_BIT_WIDTH'(4'b0101);
    localparam logic [OP_BIT_WIDTH-1:0] OP_CMP  = OP_BIT_WIDTH'(4'b0010);
    localparam logic [OP_BIT_WIDTH-1:0] OP_CMPI = OP_BIT_WIDTH'(4'b1010);
    localparam logic [OP_BIT_WIDTH-1:0] OP_BR   = OP_BIT_WIDTH'(4'b0110);
    localparam logic [OP_BIT_WIDTH-1:0] OP_JAL  = OP_BIT_WIDTH'(4'b1011);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t        state_q;
    state_t        state_n;
    logic [CW-1:0] wait_cnt;
    logic          bus_err_q;

    logic is_alu, is_alui, is_lw, is_sw;
    logic is_cmp, is_cmpi, is_br, is_jal, is_ill;

    logic run;
    logic req_i, we_i, ir_i, pc_i, imm_pc_i;
    logic wr_i, ill_i, ret_i;
    logic [1:0] sel_i;

    logic ex_act;
    logic mvhi_v;

    assign run = lock & ~reset;

    // Instruction class decode from the primary opcode
    always_comb begin
        is_alu  = (op1 == OP_ALU);
        is_alui = (op1 == OP_ALUI);
        is_lw   = (op1 == OP_LW);
        is_sw   = (op1 == OP_SW);
        is_cmp  = (op1 == OP_CMP);
        is_cmpi = (op1 == OP_CMPI);
        is_br   = (op1 == OP_BR);
        is_jal  = (op1 == OP_JAL);
        is_ill  = ~(is_alu | is_alui | is_lw | is_sw |
                    is_cmp | is_cmpi | is_br | is_jal);
    end

    // Execute-stage controls, held through EXEC, MEM and WB
    always_comb begin
        ex_act     = (state_q == S_EXEC) || (state_q == S_MEM) ||
                     (state_q == S_WB);
        mvhi_v     = op1[3] & ~op1[1] & op2[0] & op2[1];
        useZeroExe = 1'b0;
        useImmExe  = 1'b0;
        isMvhi     = 1'b0;
        opAlu      = '0;
        opCond     = '0;
        if (ex_act) begin
            isMvhi     = mvhi_v;
            useZeroExe = (is_br & op2[2]) | mvhi_v;
            useImmExe  = op1[3] | is_sw;
            opAlu      = (is_cmp | is_cmpi | is_br) ? OP2_SUB : op2;
            opCond     = op2;
        end
    end

    // Next-state and strobe generation
    always_comb begin
        state_n  = state_q;
        req_i    = 1'b0;
        we_i     = 1'b0;
        ir_i     = 1'b0;
        pc_i     = 1'b0;
        imm_pc_i = 1'b0;
        wr_i     = 1'b0;
        sel_i    = 2'd0;
        ill_i    = 1'b0;
        ret_i    = 1'b0;
        case (state_q)
            S_FETCH: begin
                req_i = 1'b1;
                if (memReady) begin
                    ir_i    = 1'b1;
                    pc_i    = 1'b1;
                    state_n = S_DECODE;
                end else if (wait_cnt == CNT_LIM) begin
                    state_n = S_ERR;
                end
            end
            S_DECODE: begin
                if (is_ill) begin
                    ill_i   = 1'b1;
                    state_n = S_FETCH;
                end else begin
                    state_n = S_EXEC;
                end
            end
            S_EXEC: begin
                if (is_br) begin
                    pc_i     = outCond;
                    imm_pc_i = outCond;
                    ret_i    = 1'b1;
                    state_n  = S_FETCH;
                end else if (is_jal) begin
                    pc_i     = 1'b1;
                    imm_pc_i = 1'b1;
                    state_n  = S_WB;
                end else if (is_lw | is_sw) begin
                    state_n = S_MEM;
                end else begin
                    state_n = S_WB;
                end
            end
            S_MEM: begin
                req_i = 1'b1;
                we_i  = is_sw;
                if (memReady) begin
                    if (is_sw) begin
                        ret_i   = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        state_n = S_WB;
                    end
                end else if (wait_cnt == CNT_LIM) begin
                    state_n = S_ERR;
                end
            end
            S_WB: begin
                wr_i    = 1'b1;
                sel_i   = is_jal ? 2'd2 : (is_lw ? 2'd1 : 2'd0);
                ret_i   = 1'b1;
                state_n = S_FETCH;
            end
            S_ERR: begin
                state_n = S_ERR;
            end
            default: begin
                state_n = S_FETCH;
            end
        endcase
        if (!lock) begin
            state_n = state_q;
        end
    end

    assign memReq       = req_i & run;
    assign memWe        = we_i & run;
    assign irWrtEn      = ir_i & run;
    assign pcWrtEn      = pc_i & run;
    assign useImmPc     = imm_pc_i;
    assign wrtEnReg     = wr_i & run;
    assign wrtRegSel    = sel_i;
    assign illegalOp    = ill_i & run;
    assign instrRetired = ret_i & run;
    assign state        = state_q;
    assign busErr       = bus_err_q;

    // State register; lock freezes it
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else if (lock) begin
            state_q <= state_n;
        end
    end

    // Memory wait counter: restarts per request, counts stalled cycles
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (lock) begin
            if ((state_n != state_q) &&
                ((state_n == S_FETCH) || (state_n == S_MEM))) begin
                wait_cnt <= '0;
            end else if (memReady) begin
                wait_cnt <= '0;
            end else if (req_i) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    // Sticky bus error flag, set on entry to the error trap
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_err_q <= 1'b0;
        end else if (lock && (state_n == S_ERR)) begin
            bus_err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mc_proc_controller.sv
// Randomized bench for mc_proc_controller: per-instruction expected
// state/strobe traces built from the instruction class and memory latencies.
module tb_mc_proc_controller;

    logic       clk;
    logic       reset;
    logic       lock;
    logic [3:0] op1;
    logic [3:0] op2;
    logic       outCond;
    logic       memReady;
    logic       memReq, memWe, irWrtEn, pcWrtEn, useImmPc, wrtEnReg;
    logic [1:0] wrtRegSel;
    logic       useZeroExe, useImmExe, isMvhi;
    logic [3:0] opAlu, opCond;
    logic [2:0] state;
    logic       busErr, illegalOp, instrRetired;

    int nchk = 0;
    int nfail = 0;

    mc_proc_controller dut (
        .clk(clk), .reset(reset), .lock(lock),
        .op1(op1), .op2(op2), .outCond(outCond), .memReady(memReady),
        .memReq(memReq), .memWe(memWe), .irWrtEn(irWrtEn),
        .pcWrtEn(pcWrtEn), .useImmPc(useImmPc), .wrtEnReg(wrtEnReg),
        .wrtRegSel(wrtRegSel), .useZeroExe(useZeroExe),
        .useImmExe(useImmExe), .isMvhi(isMvhi), .opAlu(opAlu),
        .opCond(opCond), .state(state), .busErr(busErr),
        .illegalOp(illegalOp), .instrRetired(instrRetired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        rdy;
        logic [10:0] so;
    } ent_t;

    logic [10:0] so_got;
    logic [10:0] ex_got;
    assign so_got = {memReq, memWe, irWrtEn, pcWrtEn, useImmPc, wrtEnReg,
                     wrtRegSel, illegalOp, instrRetired, busErr};
    assign ex_got = {useZeroExe, useImmExe, isMvhi, opAlu, opCond};

    localparam logic [10:0] M_RST  = 11'b11110100110;
    localparam logic [10:0] M_LOCK = 11'b11110100111;
    localparam logic [10:0] M_NOSEL = 11'b11111100111;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // 0 ALU 1 ALUI 2 LW 3 SW 4 CMP 5 CMPI 6 BR 7 JAL 8 illegal
    function automatic int cls(input logic [3:0] a);
        case (a)
            4'b0000: return 0;
            4'b1000: return 1;
            4'b1001: return 2;
            4'b0101: return 3;
            4'b0010: return 4;
            4'b1010: return 5;
            4'b0110: return 6;
            4'b1011: return 7;
            default: return 8;
        endcase
    endfunction

    function automatic logic [10:0] exctl(input logic [3:0] a,
                                          input logic [3:0] b);
        int c;
        logic mv, z, im;
        logic [3:0] alu;
        c   = cls(a);
        mv  = a[3] & ~a[1] & b[0] & b[1];
        z   = ((c == 6) & b[2]) | mv;
        im  = a[3] | (c == 3);
        alu = (c == 4 || c == 5 || c == 6) ? 4'b0110 : b;
        return {z, im, mv, alu, b};
    endfunction

    function automatic ent_t mk(input logic [2:0] st, input logic r,
                                input logic [10:0] so);
        ent_t e;
        e.st  = st;
        e.rdy = r;
        e.so  = so;
        return e;
    endfunction

    function automatic int lat();
        if ($urandom_range(0, 9) == 0) return $urandom_range(14, 18);
        return $urandom_range(0, 3);
    endfunction

    task automatic do_reset();
        reset    = 1'b1;
        lock     = 1'($urandom);
        memReady = 1'($urandom);
        #2;
        chk("rst_strobes", so_got & M_RST, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        lock  = 1'b1;
        chk("rst_state", state, 0);
        chk("rst_buserr", busErr, 0);
    endtask

    task automatic locked_cycle(input ent_t e);
        lock     = 1'b0;
        memReady = 1'($urandom);
        #2;
        chk("lock_state", state, e.st);
        chk("lock_strobes", so_got & M_LOCK, {10'b0, e.so[0]});
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [3:0] a, input logic [3:0] b,
                             input logic c, input int fl, input int ml,
                             input int lk_at, input int rst_at,
                             input int lk_pct);
        ent_t plan[$];
        ent_t e;
        int k;
        logic err;
        logic done;
        logic r;
        logic sw;
        logic [1:0] sel;
        logic [10:0] m;
        k    = cls(a);
        err  = 1'b0;
        done = 1'b0;
        sw   = (k == 3);
        for (int i = 0; i < 16 && i <= fl; i++) begin
            r = (i == fl);
            plan.push_back(mk(3'd0, r, {2'b10, r, r, 7'b0}));
        end
        if (fl >= 16) begin
            err = 1'b1;
        end else if (k == 8) begin
            plan.push_back(mk(3'd1, 1'b0, 11'b00000000100));
            done = 1'b1;
        end else begin
            plan.push_back(mk(3'd1, 1'b0, 11'b0));
            if (k == 6) begin
                plan.push_back(mk(3'd2, 1'b0, {3'b000, c, c, 6'b000010}));
                done = 1'b1;
            end else if (k == 7) begin
                plan.push_back(mk(3'd2, 1'b0, {5'b00011, 6'b0}));
            end else begin
                plan.push_back(mk(3'd2, 1'b0, 11'b0));
            end
            if (k == 2 || k == 3) begin
                for (int i = 0; i < 16 && i <= ml; i++) begin
                    r = (i == ml);
                    plan.push_back(mk(3'd3, r,
                        {1'b1, sw, 4'b0, 2'b00, 1'b0, r & sw, 1'b0}));
                end
                if (ml >= 16) err = 1'b1;
                else if (sw) done = 1'b1;
            end
            if (!done && !err) begin
                sel = (k == 7) ? 2'd2 : ((k == 2) ? 2'd1 : 2'd0);
                plan.push_back(mk(3'd4, 1'b0,
                    {5'b0, 1'b1, sel, 1'b0, 1'b1, 1'b0}));
            end
        end
        if (err) begin
            plan.push_back(mk(3'd5, 1'b0, 11'b1));
            plan.push_back(mk(3'd5, 1'b0, 11'b1));
        end

        op1     = a;
        op2     = b;
        outCond = c;
        foreach (plan[j]) begin
            e = plan[j];
            while ($urandom_range(0, 99) < lk_pct) locked_cycle(e);
            if (j == lk_at) repeat (5) locked_cycle(e);
            if (j == rst_at) begin
                do_reset();
                return;
            end
            lock = 1'b1;
            if (e.st == 3'd0 || e.st == 3'd3) memReady = e.rdy;
            else memReady = 1'($urandom);
            #2;
            chk("state", state, e.st);
            m = (e.st == 3'd4) ? 11'h7FF : M_NOSEL;
            chk("strobes", so_got & m, e.so & m);
            if (e.st == 3'd2 || e.st == 3'd3 || e.st == 3'd4)
                chk("exec_ctl", ex_got, exctl(a, b));
            @(posedge clk);
            #1;
        end
        if (err) do_reset();
    endtask

    initial begin
        reset    = 1'b1;
        lock     = 1'b1;
        op1      = 4'b0;
        op2      = 4'b0;
        outCond  = 1'b0;
        memReady = 1'b0;
        do_reset();
        do_reset();

        run_instr(4'b0000, 4'b0011, 1'b0, 0, 0, -1, -1, 0);
        run_instr(4'b1001, 4'b0001, 1'b0, 0, 3, -1, -1, 0);
        run_instr(4'b0110, 4'b0100, 1'b1, 0, 0, -1, -1, 0);
        run_instr(4'b0110, 4'b0100, 1'b0, 0, 0, -1, -1, 0);
        run_instr(4'b0101, 4'b0010, 1'b0, 0, 20, -1, -1, 0);
        run_instr(4'b0101, 4'b0010, 1'b0, 0, 15, -1, -1, 0);
        run_instr(4'b0000, 4'b0000, 1'b0, 16, 0, -1, -1, 0);
        run_instr(4'b0000, 4'b0000, 1'b0, 15, 0, -1, -1, 0);
        run_instr(4'b0101, 4'b0111, 1'b0, 0, 8, 5, -1, 0);
        run_instr(4'b0101, 4'b0111, 1'b0, 1, 10, -1, 7, 0);
        run_instr(4'b0011, 4'b1111, 1'b1, 2, 0, -1, -1, 0);
        run_instr(4'b1011, 4'b0101, 1'b0, 0, 0, -1, -1, 0);
        run_instr(4'b1000, 4'b0011, 1'b0, 0, 0, -1, -1, 0);
        run_instr(4'b1010, 4'b1001, 1'b1, 0, 0, 2, -1, 0);

        for (int n = 0; n < 250; n++) begin
            run_instr(4'($urandom), 4'($urandom), 1'($urandom),
                      lat(), lat(), -1,
                      ($urandom_range(0, 19) == 0) ? 3 : -1, 15);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
